// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - architectural PC owner and fetch/exec/commit sequencer
//
// Purpose:
//   Runs each instruction through FETCH then EXEC.
//   On a commit it chooses the next PC from three sources:
//     - the sequential address pc+4,
//     - a taken branch or jump target,
//     - TRAP_VEC, when a taken target is not word-aligned.
//   Optional retire/taken statistics counters are built only when the macro
//   BR_STATS_EN is defined.
//
// Ports:
//   clk, rst        rising-edge clock; asynchronous active-high reset
//   fetch_req       request to imem, high in FETCH only
//   fetch_addr      fetch address, equal to pc
//   fetch_ack       imem returned the instruction; only looked at in FETCH
//   br_taken        branch-condition result for the instruction in EXEC
//   br_target       branch/jump target for the instruction in EXEC
//   stall           holds EXEC while UART/LSU is busy
//   pc, pc_plus4    current PC and its link value
//   commit          1-cycle retire pulse
//   misalign_trap   1-cycle pulse coincident with commit on a misaligned taken target
//   bad_target      last faulting target
//   commit_cnt      retired-instruction count (BR_STATS_EN), else 0
//   taken_cnt       taken-redirect count (BR_STATS_EN), else 0

module pc_redirect_ctrl #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0]   TRAP_VEC = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst,
  output logic            fetch_req,
  output logic [XLEN-1:0] fetch_addr,
  input  logic            fetch_ack,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            stall,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            commit,
  output logic            misalign_trap,
  output logic [XLEN-1:0] bad_target,
  output logic [31:0]     commit_cnt,
  output logic [31:0]     taken_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc_nxt;

  assign fetch_addr = pc;
  assign pc_plus4   = pc + XLEN'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      bad_target <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (misalign_trap) begin
        bad_target <= br_target;
      end
    end
  end

  // commit and misalign_trap are combinational on EXEC && !stall, so a reset
  // (which forces IDLE) can never let a commit escape.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    fetch_req     = 1'b0;
    commit        = 1'b0;
    misalign_trap = 1'b0;
    unique case (state)
      ST_IDLE: begin
        state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        fetch_req = 1'b1;
        if (fetch_ack) begin
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!stall) begin
          commit    = 1'b1;
          state_nxt = ST_FETCH;
          if (!br_taken) begin
            pc_nxt = pc_plus4;
          end else if (br_target[1:0] != 2'b00) begin
            pc_nxt        = TRAP_VEC;
            misalign_trap = 1'b1;
          end else begin
            pc_nxt = br_target;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef BR_STATS_EN
  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_cnt <= '0;
      taken_cnt  <= '0;
    end else if (commit) begin
      if (commit_cnt != 32'hFFFF_FFFF) begin
        commit_cnt <= commit_cnt + 32'd1;
      end
      if (br_taken && (taken_cnt != 32'hFFFF_FFFF)) begin
        taken_cnt <= taken_cnt + 32'd1;
      end
    end
  end
`else
  assign commit_cnt = 32'd0;
  assign taken_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb/tb_pc_redirect_ctrl.sv - directed plus random bench for pc_redirect_ctrl

module tb_pc_redirect_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
`ifdef BR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ack = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        stall = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        commit;
  logic        misalign_trap;
  logic [31:0] bad_target;
  logic [31:0] commit_cnt;
  logic [31:0] taken_cnt;

  pc_redirect_ctrl #(
    .XLEN(32), .RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)
  ) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
    .br_taken(br_taken), .br_target(br_target), .stall(stall),
    .pc(pc), .pc_plus4(pc_plus4),
    .commit(commit), .misalign_trap(misalign_trap), .bad_target(bad_target),
    .commit_cnt(commit_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: phase 0 = waiting after reset, 1 = fetching, 2 = executing.
  int          m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_bad;
  logic [31:0] m_ccnt;
  logic [31:0] m_tcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_pc    = RESET_PC;
    m_bad   = '0;
    m_ccnt  = '0;
    m_tcnt  = '0;
  endtask

  // One clock: drive inputs, check outputs at the falling edge, then advance
  // the model on the rising edge.
  task automatic cycle(input logic ack, input logic tk, input logic [31:0] tgt, input logic stl);
    logic will_commit;
    logic will_trap;
    fetch_ack = ack;
    br_taken  = tk;
    br_target = tgt;
    stall     = stl;
    will_commit = (m_phase == 2) && !stl;
    will_trap   = will_commit && tk && (tgt[1:0] != 2'b00);
    #4;
    chk("fetch_req",  {31'd0, fetch_req}, {31'd0, m_phase == 1});
    chk("fetch_addr", fetch_addr, m_pc);
    chk("pc",         pc, m_pc);
    chk("pc_plus4",   pc_plus4, m_pc + 32'd4);
    chk("commit",     {31'd0, commit}, {31'd0, will_commit});
    chk("misalign",   {31'd0, misalign_trap}, {31'd0, will_trap});
    chk("bad_target", bad_target, m_bad);
    chk("commit_cnt", commit_cnt, STATS ? m_ccnt : 32'd0);
    chk("taken_cnt",  taken_cnt,  STATS ? m_tcnt : 32'd0);
    @(posedge clk);
    if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (ack) m_phase = 2;
    end else if (!stl) begin
      if (m_ccnt != 32'hFFFF_FFFF) m_ccnt = m_ccnt + 1;
      if (tk && m_tcnt != 32'hFFFF_FFFF) m_tcnt = m_tcnt + 1;
      if (!tk) m_pc = m_pc + 32'd4;
      else if (tgt[1:0] != 2'b00) begin
        m_pc  = TRAP_VEC;
        m_bad = tgt;
      end else m_pc = tgt;
      m_phase = 1;
    end
    #1;
  endtask

  // Run one instruction: fetch (acked immediately) then execute.
  task automatic instr(input logic tk, input logic [31:0] tgt);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, tk, tgt, 1'b0);
  endtask

  initial begin
    logic [31:0] t;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_pc",        pc, RESET_PC);
    chk("rst_fetch_req", {31'd0, fetch_req}, 32'd0);
    chk("rst_commit",    {31'd0, commit}, 32'd0);
    rst = 1'b0;

    cycle(1'b0, 1'b0, 32'h0, 1'b0);         // IDLE
    instr(1'b0, 32'h0);                      // pc 0x0
    instr(1'b0, 32'h0);                      // pc 0x4
    instr(1'b1, 32'h40);                     // pc 0x8, taken to 0x40
    cycle(1'b1, 1'b0, 32'h0, 1'b0);          // fetch 0x40
    repeat (3) cycle(1'b0, 1'b1, 32'h44, 1'b1); // stalled, branch ignored
    cycle(1'b0, 1'b0, 32'h0, 1'b0);          // commit
    instr(1'b1, 32'h42);                     // misaligned -> trap vector
    instr(1'b1, 32'hFFFF_FFFC);              // jump to top of space
    instr(1'b0, 32'h0);                      // wrap to 0x0
    cycle(1'b0, 1'b0, 32'h0, 1'b0);          // fetch waits
    cycle(1'b0, 1'b0, 32'h0, 1'b1);          // stall in FETCH has no effect
    cycle(1'b1, 1'b0, 32'h0, 1'b1);          // ack wins over stall
    cycle(1'b0, 1'b0, 32'h0, 1'b0);          // commit
    cycle(1'b1, 1'b1, 32'h80, 1'b0);         // move to EXEC
    cycle(1'b0, 1'b1, 32'h80, 1'b0);         // taken to 0x80

    // Reset in the middle of FETCH.
    fetch_ack = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("abort_pc",        pc, RESET_PC);
    chk("abort_fetch_req", {31'd0, fetch_req}, 32'd0);
    chk("abort_commit",    {31'd0, commit}, 32'd0);
    chk("abort_bad",       bad_target, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 400; i++) begin
      t = $urandom;
      if ($urandom_range(3) != 0) t[1:0] = 2'b00;
      if ($urandom_range(15) == 0) t = 32'hFFFF_FFFC;
      cycle(1'($urandom_range(1)), 1'($urandom_range(1)), t,
            1'($urandom_range(2) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
